alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_PASS   = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SHW-1:0]        r_cnt;
  logic [XLEN-1:0]       r_result;
  logic                  r_mul_hi;
  logic                  r_div_rem;
  logic [2*XLEN-1:0]     r_prod;
  logic [2*XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]       r_mplier;
  logic                  r_neg_p;
  logic [XLEN-1:0]       r_rem;
  logic [XLEN-1:0]       r_quo;
  logic [XLEN-1:0]       r_dvsr;
  logic                  r_neg_q;
  logic                  r_neg_r;

  function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v, input logic neg);
    f_mag = neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_mag2(input logic [2*XLEN-1:0] v, input logic neg);
    f_mag2 = neg ? (~v + 1'b1) : v;
  endfunction

  logic            w_accept;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_dsigned;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_iter;
  logic            w_ma_neg;
  logic            w_mb_neg;
  logic            w_da_neg;
  logic            w_db_neg;
  logic            w_last;
  logic [XLEN-1:0] w_alu;

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_is_mul   = (op[4:2] == 3'b100);
  assign w_is_div   = (op[4:2] == 3'b101);
  assign w_dsigned  = (op == OP_DIV) || (op == OP_REM);
  assign w_div_zero = (b == '0);
  assign w_div_ovf  = w_dsigned && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
  assign w_iter     = w_is_mul || (w_is_div && !w_div_zero && !w_div_ovf);
  assign w_ma_neg   = a[XLEN-1] && ((op == OP_MULH) || (op == OP_MULHSU));
  assign w_mb_neg   = b[XLEN-1] && (op == OP_MULH);
  assign w_da_neg   = a[XLEN-1] && w_dsigned;
  assign w_db_neg   = b[XLEN-1] && w_dsigned;
  assign w_last     = (r_cnt == SHW'(XLEN-1));

  // Single-cycle results, including the divide-by-zero and overflow shortcuts.
  always_comb begin
    w_alu = '0;
    case (op)
      OP_ADD:           w_alu = a + b;
      OP_SUB:           w_alu = a - b;
      OP_AND:           w_alu = a & b;
      OP_OR:            w_alu = a | b;
      OP_XOR:           w_alu = a ^ b;
      OP_SLL:           w_alu = a << b[SHW-1:0];
      OP_SRL:           w_alu = a >> b[SHW-1:0];
      OP_SRA:           w_alu = $signed(a) >>> b[SHW-1:0];
      OP_SLT:           w_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:          w_alu = {{(XLEN-1){1'b0}}, (a < b)};
      OP_PASS:          w_alu = b;
      OP_DIV, OP_DIVU:  w_alu = w_div_zero ? '1 : a;
      OP_REM, OP_REMU:  w_alu = w_div_zero ? a : '0;
      default:          w_alu = '0;
    endcase
  end

  logic [2*XLEN-1:0] w_prod_nxt;
  logic [2*XLEN-1:0] w_prod_fin;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_div_res;

  assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign w_prod_fin = f_mag2(w_prod_nxt, r_neg_p);
  assign w_mul_res  = r_mul_hi ? w_prod_fin[2*XLEN-1:XLEN] : w_prod_fin[XLEN-1:0];

  // Borrow out of the (XLEN+1)-bit trial subtraction decides the quotient bit.
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvsr};
  assign w_ge      = !w_diff[XLEN];
  assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
  assign w_div_res = r_div_rem ? f_mag(w_rem_nxt, r_neg_r) : f_mag(w_quo_nxt, r_neg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_is_mul)     w_state_nxt = MUL;
          else if (w_iter)  w_state_nxt = DIV;
          else              w_state_nxt = DONE;
        end
      end
      MUL, DIV: if (w_last) w_state_nxt = DONE;
      DONE:     if (out_ready) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == MUL) || (r_state == DIV);
  end

  // Both engines are loaded on every acceptance; only the selected one iterates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_result  <= '0;
      r_mul_hi  <= 1'b0;
      r_div_rem <= 1'b0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg_p   <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      if (!w_iter) r_result <= w_alu;
      r_mul_hi  <= (op != OP_MUL);
      r_div_rem <= op[1];
      r_prod    <= '0;
      r_mcand   <= {{XLEN{1'b0}}, f_mag(a, w_ma_neg)};
      r_mplier  <= f_mag(b, w_mb_neg);
      r_neg_p   <= w_ma_neg ^ w_mb_neg;
      r_rem     <= '0;
      r_quo     <= f_mag(a, w_da_neg);
      r_dvsr    <= f_mag(b, w_db_neg);
      r_neg_q   <= w_da_neg ^ w_db_neg;
      r_neg_r   <= w_da_neg;
    end else if (r_state == MUL) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
      if (w_last) r_result <= w_mul_res;
    end else if (r_state == DIV) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + SHW'(1);
      if (w_last) r_result <= w_div_res;
    end
  end

  assign result = r_result;
  assign zero   = (r_result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed and random ops on a 32-bit and an 8-bit
// instance, compared against an arithmetic reference model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        iv32, ir32, ov32, or32, z32, bz32;
  logic [4:0]  op32;
  logic [31:0] a32, b32, r32;

  logic        iv8, ir8, ov8, or8, z8, bz8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, r8;

  int n_chk = 0;
  int n_err = 0;

  alu_muldiv #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .result(r32),
    .zero(z32), .busy(bz32)
  );

  alu_muldiv #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .result(r8),
    .zero(z8), .busy(bz8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic, masked to width w.
  function automatic logic [31:0] ref_op(input int w, input logic [4:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub, up;
    longint      sa, sb, t;
    int          sh;
    bit          ovf;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = (w == 8) ? longint'(byte'(a[7:0])) : longint'(int'(a));
    sb   = (w == 8) ? longint'(byte'(b[7:0])) : longint'(int'(b));
    sh   = int'(b[4:0]) % w;
    ovf  = (sa == -(longint'(1) <<< (w - 1))) && (sb == -1);
    up   = 64'd0;
    case (op)
      5'd0:  up = ua + ub;
      5'd1:  up = ua - ub;
      5'd2:  up = ua & ub;
      5'd3:  up = ua | ub;
      5'd4:  up = ua ^ ub;
      5'd5:  up = ua << sh;
      5'd6:  up = ua >> sh;
      5'd7:  begin t = sa >>> sh; up = t; end
      5'd8:  up = 64'(sa < sb);
      5'd9:  up = 64'(ua < ub);
      5'd10: up = ub;
      5'd16: begin t = sa * sb; up = t; end
      5'd17: begin t = sa * sb; up = t >>> w; end
      5'd18: begin t = sa * longint'(ub); up = t >>> w; end
      5'd19: up = (ua * ub) >> w;
      5'd20: begin
        if (ub == 0) up = mask;
        else if (ovf) up = ua;
        else begin t = sa / sb; up = t; end
      end
      5'd21: up = (ub == 0) ? mask : ua / ub;
      5'd22: begin
        if (ub == 0) up = ua;
        else if (ovf) up = 64'd0;
        else begin t = sa % sb; up = t; end
      end
      5'd23: up = (ub == 0) ? ua : ua % ub;
      default: up = 64'd0;
    endcase
    return 32'(up & mask);
  endfunction

  function automatic int exp_lat(input int w, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, ua, ub;
    mask = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
    ua = a & mask;
    ub = b & mask;
    if (op >= 5'd16 && op <= 5'd19) return w + 1;
    if (op >= 5'd20 && op <= 5'd23) begin
      if (ub == 0) return 1;
      if ((op == 5'd20 || op == 5'd22) && ua == (32'd1 << (w - 1)) && ub == mask) return 1;
      return w + 1;
    end
    return 1;
  endfunction

  function automatic logic g_ov(input bit w8); return w8 ? ov8 : ov32; endfunction
  function automatic logic g_ir(input bit w8); return w8 ? ir8 : ir32; endfunction
  function automatic logic g_bz(input bit w8); return w8 ? bz8 : bz32; endfunction
  function automatic logic g_z(input bit w8);  return w8 ? z8 : z32;   endfunction
  function automatic logic [31:0] g_res(input bit w8); return w8 ? {24'd0, r8} : r32; endfunction

  task automatic drive(input bit w8, input logic v, input logic [4:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    if (w8) begin
      iv8 = v; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      iv32 = v; op32 = o; a32 = x; b32 = y;
    end
  endtask

  // Issue one op, scramble inputs (with random in_valid) while it runs,
  // then check latency, busy time, result and zero; optionally see it consumed.
  task automatic run_op(input bit w8, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit consume, input string tag);
    int          w, lat, bcnt, elat;
    logic [31:0] exp;
    w    = w8 ? 8 : 32;
    exp  = ref_op(w, op, a, b);
    elat = exp_lat(w, op, a, b);
    bcnt = 0;
    drive(w8, 1'b1, op, a, b);
    @(posedge clk); #1;
    lat = 1;
    drive(w8, 1'b0, 5'($urandom), $urandom, $urandom);
    while (!g_ov(w8) && lat < 200) begin
      if (g_bz(w8) && !g_ir(w8)) bcnt++;
      drive(w8, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom);
      @(posedge clk); #1;
      lat++;
    end
    drive(w8, 1'b0, 5'd0, 32'd0, 32'd0);
    check({tag, ".latency"}, 64'(lat), 64'(elat));
    check({tag, ".busy_cycles"}, 64'(bcnt), 64'((elat > 1) ? w : 0));
    check({tag, ".result"}, {32'd0, g_res(w8)}, {32'd0, exp});
    check({tag, ".zero"}, {63'd0, g_z(w8)}, {63'd0, (exp == 32'd0)});
    if (consume) begin
      @(posedge clk); #1;
      check({tag, ".consumed"}, {62'd0, g_ir(w8), g_ov(w8)}, 64'b10);
    end
  endtask

  logic [4:0] ops [21] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                          5'd9, 5'd10, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21,
                          5'd22, 5'd23, 5'd11, 5'd29};

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    or32 = 1'b1;
    or8  = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check("reset32", {ir32, ov32, bz32, z32, r32}, {1'b1, 1'b0, 1'b0, 1'b1, 32'd0});
    check("reset8", {ir8, ov8, bz8, z8, r8}, {1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 5'd1,  32'd5,          32'd7,          1, "sub_5_7");
    run_op(0, 5'd17, 32'h8000_0000,  32'h8000_0000,  1, "mulh_min");
    run_op(0, 5'd16, 32'h8000_0000,  32'h8000_0000,  1, "mul_min");
    run_op(0, 5'd20, -32'sd7,        32'd2,          1, "div_m7_2");
    run_op(0, 5'd22, -32'sd7,        32'd2,          1, "rem_m7_2");
    run_op(0, 5'd21, 32'd7,          32'd0,          1, "divu_by0");
    run_op(0, 5'd23, 32'd7,          32'd0,          1, "remu_by0");
    run_op(0, 5'd20, 32'h8000_0000,  32'hFFFF_FFFF,  1, "div_ovf");
    run_op(0, 5'd22, 32'h8000_0000,  32'hFFFF_FFFF,  1, "rem_ovf");
    run_op(0, 5'd18, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1, "mulhsu_m1");
    run_op(0, 5'd4,  32'h1234_5678,  32'h1234_5678,  1, "xor_zero");
    run_op(0, 5'd7,  32'h8000_0000,  32'd31,         1, "sra_31");
    run_op(0, 5'd8,  32'hFFFF_FFFF,  32'd1,          1, "slt_neg");
    run_op(0, 5'd9,  32'hFFFF_FFFF,  32'd1,          1, "sltu_big");
    run_op(0, 5'd11, 32'd99,         32'd1,          1, "undef_11");

    // Backpressure: result held, requests ignored while out_ready is low.
    or32 = 1'b0;
    run_op(0, 5'd0, 32'd3, 32'd4, 0, "bp_add");
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, 5'($urandom), $urandom, $urandom);
      @(posedge clk); #1;
      check("bp_hold", {30'd0, ov32, ir32, r32}, {30'd0, 1'b1, 1'b0, 32'd7});
    end
    drive(0, 1'b0, 5'd0, 32'd0, 32'd0);
    or32 = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {62'd0, ir32, ov32}, 64'b10);

    // Reset in the middle of a DIVU.
    drive(0, 1'b1, 5'd21, 32'd1000000, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 5'd0, 32'd0, 32'd0);
    repeat (11) @(posedge clk);
    #2;
    check("rst_pre_busy", {63'd0, bz32}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {ir32, ov32, bz32, z32, r32}, {1'b1, 1'b0, 1'b0, 1'b1, 32'd0});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_no_result", {62'd0, ir32, ov32}, 64'b10);
    run_op(0, 5'd0, 32'd1, 32'd1, 1, "post_rst_add");

    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 20)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      run_op(0, rop, ra, rb, 1, "rand32");
    end

    run_op(1, 5'd7,  32'h80, 32'h03, 1, "sra8");
    run_op(1, 5'd19, 32'hFF, 32'hFF, 1, "mulhu8");
    run_op(1, 5'd17, 32'h80, 32'hFF, 1, "mulh8");
    run_op(1, 5'd20, 32'h80, 32'hFF, 1, "div8_ovf");
    for (int i = 0; i < 25; i++) begin
      rop = ops[$urandom_range(0, 20)];
      ra  = $urandom_range(0, 255);
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(0, 255);
      run_op(1, rop, ra, rb, 1, "rand8");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
